thermometer_serializer: RTL and testbench
=========================================

Name: thermometer_serializer

Overview:
Count-to-vector decoder: the inverse direction of the population-count (ones counter) blocks. It accepts a binary count N over a valid/ready handshake and expands it to a W-bit thermometer word, with bits [N-1:0] set and all others clear. The word is driven out bit-serially, LSB first, over a valid/ready stream, and is also presented in parallel. It acts as a stimulus/expander stage feeding the serial datapaths and counter checkers.

Parameters:
W, 7, thermometer word width in bits; W >= 1.
CW, 4, input count width; requires 2**CW > W.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  in_count is valid
in_ready  out  1  block can accept a count
in_count  in  CW  unsigned count N
out_valid  out  1  out_bit and the frame markers are valid
out_ready  in  1  downstream accepts the current bit
out_bit  out  1  current serial thermometer bit
out_first  out  1  current bit is bit index 0 of the frame
out_last  out  1  current bit is bit index W-1 of the frame
word  out  W  parallel thermometer word of the current or most recent frame
word_valid  out  1  one-cycle pulse when word is updated
sat_err  out  1  one-cycle pulse when an accepted count exceeded W

Behaviour:
- Reset is synchronous: with rst_n low at a rising edge, state becomes IDLE and idx=0, count_r=0, word=0. Outputs then read in_ready=1 and out_valid=out_bit=out_first=out_last=word_valid=sat_err=0.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid && in_ready: count_r <= min(in_count, W), word <= thermo(count_r), idx <= 0, go to SHIFT.
  - word_valid and sat_err (when in_count > W) pulse high the cycle after the accept, for exactly one cycle.
- SHIFT:
  - in_ready=0 and out_valid=1.
  - out_bit = (idx < count_r), out_first = (idx==0), out_last = (idx==W-1).
  - On out_valid && out_ready: if idx==W-1, go to IDLE; else idx <= idx+1.
- Latency:
  - First bit is valid one cycle after the input accept.
  - A full frame takes W out-handshakes.
  - in_ready reasserts the cycle after the last handshake, so the minimum period is W+1 cycles per count.
- Backpressure: while out_valid && !out_ready, out_bit/out_first/out_last/idx hold stable; there is no bit loss or duplication.
- in_count is sampled only on accept; changes to in_count during SHIFT are ignored.
- Word values: N=0 gives an all-zero frame, N=W gives an all-ones frame.
- W=1: out_first and out_last are both high on the single bit.
- word holds its value after the frame ends until the next accept or reset.
- Reset mid-frame: the frame aborts, with no further out_valid; outputs equal reset values on the next cycle.
- idx width is clog2(W) (minimum 1); it never exceeds W-1 and there is no wrap.

Decomposition:
- Shared package:
  - state typedef (IDLE, SHIFT);
  - default W/CW constants;
  - a clog2-based IDX_W helper.
- Sub-module thermo_decode: combinational, CW-bit count in, W-bit thermometer out, saturating. It is reused for the parallel word and is independently testable against the ones counters: popcount(thermo(N)) == min(N,W).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, word=0, no pulses.
- N=3, W=7, out_ready=1 -> word=7'b0000111 with word_valid pulse; serial bits 1,1,1,0,0,0,0; out_first on bit 0, out_last on bit 6; in_ready high 8 cycles after accept.
- N=0, then N=7 back-to-back -> all-zero frame, then all-ones frame; word=7'b1111111; sat_err never pulses.
- N=9 (CW=4) -> saturated to 7: all-ones frame, word=7'b1111111, sat_err pulses once.
- N=5 with out_ready toggled 1,0,0,1,... -> each bit held while stalled; received stream exactly 1,1,1,1,1,0,0 with no drops or duplicates.
- N=6, rst_n=0 at bit index 3 -> next cycle out_valid=0, word=0, in_ready=1; a new N=2 afterwards yields 1,1,0,0,0,0,0.

Source files
------------

// File: rtl/thermometer_serializer_pkg.sv
// Shared types and sizing helpers for the thermometer serializer.
package thermometer_serializer_pkg;

   localparam int W_DEF  = 7;
   localparam int CW_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Bit index width; a one-bit frame still needs a one-bit index register.
   function automatic int idx_w(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/thermometer_serializer_thermo_decode.sv
// Saturating count-to-thermometer decoder: bits [N-1:0] set, N clipped at W.
module thermo_decode #(
   parameter int W  = 7,
   parameter int CW = 4
) (
   input  logic [CW-1:0] count,
   output logic [W-1:0]  thermo,
   output logic          sat
);

   always_comb begin
      thermo = '0;
      for (int i = 0; i < W; i++) begin
         thermo[i] = (int'(count) > i);
      end
      sat = (int'(count) > W);
   end

endmodule

// File: rtl/thermometer_serializer.sv
// Accepts a count, expands it to a W-bit thermometer word and streams it LSB first.
module thermometer_serializer
   import thermometer_serializer_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [CW-1:0] in_count,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_bit,
   output logic          out_first,
   output logic          out_last,
   output logic [W-1:0]  word,
   output logic          word_valid,
   output logic          sat_err
);

   localparam int IW = idx_w(W);

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] count_q, count_d;
   logic [W-1:0]  word_q, word_d;
   logic          word_valid_q, word_valid_d;
   logic          sat_err_q, sat_err_d;
   logic [W-1:0]  thermo;
   logic          sat;

   thermo_decode #(.W(W), .CW(CW)) u_thermo_decode (
      .count  (in_count),
      .thermo (thermo),
      .sat    (sat)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      count_d      = count_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      sat_err_d    = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_bit      = 1'b0;
      out_first    = 1'b0;
      out_last     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               count_d      = sat ? CW'(W) : in_count;
               word_d       = thermo;
               idx_d        = '0;
               word_valid_d = 1'b1;
               sat_err_d    = sat;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            out_valid = 1'b1;
            out_bit   = (CW'(idx_q) < count_q);
            out_first = (idx_q == '0);
            out_last  = (idx_q == IW'(W - 1));
            // The index holds while stalled, so a bit is never skipped or repeated.
            if (out_ready) begin
               if (out_last) state_d = IDLE;
               else          idx_d   = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         count_q      <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         sat_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         count_q      <= count_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         sat_err_q    <= sat_err_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign sat_err    = sat_err_q;

endmodule

// File: tb/tb_thermometer_serializer.sv
// Directed bench for thermometer_serializer with W=7, CW=4.
module tb_thermometer_serializer;

   localparam int W  = 7;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_count;
   logic          out_valid;
   logic          out_ready;
   logic          out_bit;
   logic          out_first;
   logic          out_last;
   logic [W-1:0]  word;
   logic          word_valid;
   logic          sat_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   thermometer_serializer #(.W(W), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_count   (in_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bit    (out_bit),
      .out_first  (out_first),
      .out_last   (out_last),
      .word       (word),
      .word_valid (word_valid),
      .sat_err    (sat_err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Drive one count at a falling edge; checks the accept and the pulses one cycle later.
   task automatic send(input string tag, input logic [CW-1:0] n,
                       input logic [W-1:0] exp_word, input logic exp_sat);
      in_valid = 1'b1;
      in_count = n;
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, ".word"}, 32'(word), 32'(exp_word));
      check({tag, ".word_valid"}, 32'(word_valid), 32'd1);
      check({tag, ".sat_err"}, 32'(sat_err), 32'(exp_sat));
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
   endtask

   // Receive nbits handshakes; stall=1 drives out_ready with the 1,0,0 pattern.
   task automatic recv(input string tag, input logic [W-1:0] exp, input bit stall, input int nbits);
      int got = 0;
      int cyc = 0;
      logic [W-1:0] rx = '0;
      while (got < nbits && cyc < 200) begin
         out_ready = stall ? (cyc % 3 == 0) : 1'b1;
         in_count  = CW'(cyc);
         check({tag, ".valid"}, 32'(out_valid), 32'd1);
         check({tag, ".bit"}, 32'(out_bit), 32'(exp[got]));
         check({tag, ".first"}, 32'(out_first), 32'(got == 0));
         check({tag, ".last"}, 32'(out_last), 32'(got == W - 1));
         if (cyc > 0) check({tag, ".pulses"}, 32'(word_valid | sat_err), 32'd0);
         if (out_valid && out_ready) begin
            rx[got] = out_bit;
            got++;
         end
         cyc++;
         @(negedge clk);
      end
      check({tag, ".timeout"}, 32'(got), 32'(nbits));
      if (nbits == W) begin
         check({tag, ".stream"}, 32'(rx), 32'(exp));
         check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
         check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_count  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.word", 32'(word), 32'd0);
      check("rst.pulses", 32'({word_valid, sat_err, out_bit, out_first, out_last}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send("n3", 4'd3, 7'b0000111, 1'b0);
      recv("n3", 7'b0000111, 1'b0, W);
      repeat (3) @(negedge clk);
      check("n3.word_hold", 32'(word), 32'(7'b0000111));
      check("n3.idle_out_valid", 32'(out_valid), 32'd0);

      send("n0", 4'd0, 7'b0000000, 1'b0);
      recv("n0", 7'b0000000, 1'b0, W);
      send("n7", 4'd7, 7'b1111111, 1'b0);
      recv("n7", 7'b1111111, 1'b0, W);

      send("n9", 4'd9, 7'b1111111, 1'b1);
      recv("n9", 7'b1111111, 1'b0, W);

      send("n15", 4'd15, 7'b1111111, 1'b1);
      recv("n15", 7'b1111111, 1'b1, W);

      send("n5", 4'd5, 7'b0011111, 1'b0);
      recv("n5", 7'b0011111, 1'b1, W);

      send("n6", 4'd6, 7'b0111111, 1'b0);
      recv("n6", 7'b0111111, 1'b0, 3);
      check("n6.idx3_bit", 32'(out_bit), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst.out_valid", 32'(out_valid), 32'd0);
      check("midrst.word", 32'(word), 32'd0);
      check("midrst.in_ready", 32'(in_ready), 32'd1);
      check("midrst.bits", 32'({out_bit, out_first, out_last, word_valid, sat_err}), 32'd0);
      @(negedge clk);
      check("midrst.still_idle", 32'(out_valid), 32'd0);

      send("n2", 4'd2, 7'b0000011, 1'b0);
      recv("n2", 7'b0000011, 1'b0, W);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
